// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for E-stage DIV/DIVU, holds the pipeline and writes HI/LO once.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses RUN/FIX and completes in one cycle.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       aluopE,
    input  logic             validE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             annul,
    input  logic             stall_ext,
    output logic             div_stallE,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    // state | meaning
    // IDLE  | waiting for DIV/DIVU in E
    // RUN   | one restoring shift-subtract step per cycle
    // FIX   | sign correction, results registered to hi_o/lo_o
    // DONE  | HI/LO write when stall_ext is low

    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   divisor;
    logic [2*WIDTH-1:0] rq;
    logic               signed_op, sign_q, sign_r;
    logic               is_div, start, last_step, zero_fast;
    logic [WIDTH-1:0]   abs_a, abs_b, op_a, op_b;
    logic [WIDTH-1:0]   rem, quo;
    logic [WIDTH:0]     trial;

    assign is_div    = (aluopE == EXE_DIV_OP);
    assign start     = rst & (state == IDLE) & validE & ~annul
                       & (is_div | (aluopE == EXE_DIVU_OP));
    assign abs_a     = srcaE[WIDTH-1] ? -srcaE : srcaE;
    assign abs_b     = srcbE[WIDTH-1] ? -srcbE : srcbE;
    assign op_a      = is_div ? abs_a : srcaE;
    assign op_b      = is_div ? abs_b : srcbE;
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign rem       = rq[2*WIDTH-1:WIDTH];
    assign quo       = rq[WIDTH-1:0];
    // The bit shifted out of rem is kept as the trial MSB so divisors above 2^(WIDTH-1) work.
    assign trial     = {rem, quo[WIDTH-1]} - {1'b0, divisor};

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (srcbE == '0);
`else
    assign zero_fast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (annul) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = zero_fast ? DONE : RUN;
                RUN:     if (last_step) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    if (!stall_ext) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = rst & (state != IDLE);
        hilo_we    = rst & (state == DONE) & ~stall_ext & ~annul;
        div_stallE = rst & ~annul & (start | (state == RUN) | (state == FIX));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            divisor   <= '0;
            rq        <= '0;
            signed_op <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        divisor   <= op_b;
                        rq        <= {{WIDTH{1'b0}}, op_a};
                        signed_op <= is_div;
                        sign_q    <= srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
                        sign_r    <= srcaE[WIDTH-1];
                        if (zero_fast) begin
                            hi_o <= srcaE;
                            lo_o <= '1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (!trial[WIDTH]) rq <= {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
                    else               rq <= {rq[2*WIDTH-2:0], 1'b0};
                end
                FIX: begin
                    lo_o <= (signed_op & sign_q) ? -quo : quo;
                    hi_o <= (signed_op & sign_r) ? -rem : rem;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes expected HI/LO, monitor pops on every hilo_we.
module tb_div_seq;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;

    logic        clk = 1'b0;
    logic        rst, validE, annul, stall_ext;
    logic [7:0]  aluopE;
    logic [31:0] srcaE, srcbE;
    logic        div_stallE, busy, hilo_we;
    logic [31:0] hi_o, lo_o;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    string       tag = "init";

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .aluopE(aluopE), .validE(validE),
        .srcaE(srcaE), .srcbE(srcbE), .annul(annul), .stall_ext(stall_ext),
        .div_stallE(div_stallE), .busy(busy), .hilo_we(hilo_we),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s/%s: got %h expected %h at %0t", tag, nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (hilo_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s/unexpected_write: got hi=%h lo=%h expected no write", tag, hi_o, lo_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("hi_o", hi_o, e[63:32]);
                check("lo_o", lo_o, e[31:0]);
            end
        end
    end

    // lat: cycle of the write; hold: stall_ext cycles from lat; kill_at: annul/reset cycle (-1 none)
    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int lat, input int hold, input int kill_at, input bit kill_rst);
        int end_cyc, low_at;
        tag     = name;
        end_cyc = (kill_at >= 0) ? kill_at : lat + hold;
        low_at  = (kill_at >= 0 && kill_at < lat) ? kill_at : lat;
        if (kill_at < 0) exp_q.push_back({exp_hi, exp_lo});
        aluopE = op; validE = 1'b1; srcaE = a; srcbE = b;
        for (int cyc = 0; cyc <= end_cyc; cyc++) begin
            stall_ext = (cyc >= lat) && (cyc < lat + hold);
            annul     = (cyc == kill_at) && !kill_rst;
            rst       = !((cyc == kill_at) && kill_rst);
            @(negedge clk);
            check("div_stallE", 32'(div_stallE), 32'(cyc < low_at));
            check("hilo_we", 32'(hilo_we), 32'(kill_at < 0 && cyc == end_cyc));
            @(posedge clk);
            #1;
        end
        validE = 1'b0; aluopE = 8'h00; stall_ext = 1'b0; annul = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("stall_after", 32'(div_stallE), 32'd0);
        if (kill_at < 0 || kill_rst) begin
            check("hi_held", hi_o, kill_rst ? 32'd0 : exp_hi);
            check("lo_held", lo_o, kill_rst ? 32'd0 : exp_lo);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; validE = 1'b0; annul = 1'b0; stall_ext = 1'b0;
        aluopE = 8'h00; srcaE = '0; srcbE = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(div_stallE), 32'd0);
        check("rst_we", 32'(hilo_we), 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // bubble carrying a DIV opcode must not start
        tag = "bubble";
        aluopE = OP_DIV; validE = 1'b0; srcaE = 32'd10; srcbE = 32'd3;
        @(negedge clk);
        check("stall", 32'(div_stallE), 32'd0);
        @(posedge clk);
        #1;
        aluopE = 8'h00;
        @(negedge clk);
        check("busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        run_div("divu_100_7",   OP_DIVU, 32'd100,      32'd7,      32'd2,        32'd14,       34, 0, -1, 0);
        run_div("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,      32'hFFFFFFFF, 32'hFFFFFFFD, 34, 0, -1, 0);
        run_div("div_ovf",      OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,      32'h80000000, 34, 0, -1, 0);
        run_div("div_7_m2",     OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,      32'hFFFFFFFD, 34, 0, -1, 0);
        run_div("divu_bigdiv",  OP_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1,      34, 0, -1, 0);
        run_div("annul_run",    OP_DIVU, 32'd100,      32'd7,      32'd0,        32'd0,        34, 0, 10, 0);
        run_div("divu_9_3",     OP_DIVU, 32'd9,        32'd3,      32'd0,        32'd3,        34, 0, -1, 0);
        run_div("stall_hold",   OP_DIV,  32'd1000,     32'd10,     32'd0,        32'd100,      34, 4, -1, 0);
        run_div("annul_done",   OP_DIVU, 32'd100,      32'd7,      32'd0,        32'd0,        34, 3, 35, 0);
`ifdef DIV_ZERO_FAST_EN
        run_div("divu_5_0",     OP_DIVU, 32'd5,        32'd0,      32'd5,        32'hFFFFFFFF, 1,  0, -1, 0);
        run_div("div_m5_0",     OP_DIV,  32'hFFFFFFFB, 32'd0,      32'hFFFFFFFB, 32'hFFFFFFFF, 1,  0, -1, 0);
`else
        run_div("divu_5_0",     OP_DIVU, 32'd5,        32'd0,      32'd5,        32'hFFFFFFFF, 34, 0, -1, 0);
        run_div("div_m5_0",     OP_DIV,  32'hFFFFFFFB, 32'd0,      32'hFFFFFFFB, 32'd1,        34, 0, -1, 0);
`endif
        run_div("rst_run",      OP_DIVU, 32'd100,      32'd7,      32'd0,        32'd0,        34, 0, 20, 1);
        run_div("div_100_m7",   OP_DIV,  32'd100,      32'hFFFFFFF9, 32'd2,      32'hFFFFFFF2, 34, 0, -1, 0);

        tag = "end";
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
